// File: rtl/karatsuba_booth_seq.sv
// Karatsuba partial-product engine: hi*hi, lo*lo and (hi+lo)*(hi+lo) computed one
// after another on a single radix-4 Booth datapath, one digit per clock.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for an operand set (in_ready once out of reset)
// S_MULT | iterating Booth digits for products idx 0, 1, 2
// S_DONE | all three products held, out_valid until downstream takes them
module karatsuba_booth_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_hi,
    input  logic [W-1:0]     a_lo,
    input  logic [W-1:0]     b_hi,
    input  logic [W-1:0]     b_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p_hh,
    output logic [2*W-1:0]   p_ll,
    output logic [2*W+1:0]   p_mid,
    output logic             busy
);

    localparam int OW = W + 2;
    localparam int AW = 2 * W + 4;
    localparam int ND = OW / 2;
    localparam int CW = $clog2(ND);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]         a_hi_q, a_lo_q, b_hi_q, b_lo_q;
    logic [W:0]           sa_q, sb_q;
    logic [1:0]           idx;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_nxt;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] pp;
    logic signed [AW-1:0] pp_sh;
    logic [OW-1:0]        mcand;
    logic [OW-1:0]        mplier;
    logic [OW:0]          y_ext;
    logic [2:0]           trip;
    logic [CW:0]          shamt;
    logic                 init_q;
    logic                 accept;
    logic                 step;
    logic                 last;

    // init_q keeps in_ready low during reset and for the first edge after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = init_q;
                if (in_valid && init_q) begin
                    accept    = 1'b1;
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last && (idx == 2'd2)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mcand  = '0;
        mplier = '0;
        case (idx)
            2'd0: begin
                mcand  = OW'(a_hi_q);
                mplier = OW'(b_hi_q);
            end
            2'd1: begin
                mcand  = OW'(a_lo_q);
                mplier = OW'(b_lo_q);
            end
            default: begin
                mcand  = OW'(sa_q);
                mplier = OW'(sb_q);
            end
        endcase
    end

    // Digit k looks at y[2k+1:2k-1]; the appended zero supplies y[-1].
    always_comb begin
        y_ext = {mplier, 1'b0};
        shamt = {cnt, 1'b0};
        trip  = 3'(y_ext >> shamt);
        x_ext = $signed(AW'(mcand));
        pp    = '0;
        case (trip)
            3'b001, 3'b010: pp = x_ext;
            3'b011:         pp = x_ext <<< 1;
            3'b100:         pp = -(x_ext <<< 1);
            3'b101, 3'b110: pp = -x_ext;
            default:        pp = '0;
        endcase
        pp_sh   = pp <<< shamt;
        acc_nxt = acc + pp_sh;
        last    = (cnt == CW'(ND - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            a_hi_q <= '0;
            a_lo_q <= '0;
            b_hi_q <= '0;
            b_lo_q <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            idx    <= '0;
            cnt    <= '0;
            acc    <= '0;
            p_hh   <= '0;
            p_ll   <= '0;
            p_mid  <= '0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                a_hi_q <= a_hi;
                a_lo_q <= a_lo;
                b_hi_q <= b_hi;
                b_lo_q <= b_lo;
                sa_q   <= {1'b0, a_hi} + {1'b0, a_lo};
                sb_q   <= {1'b0, b_hi} + {1'b0, b_lo};
                idx    <= '0;
                cnt    <= '0;
                acc    <= '0;
            end else if (step) begin
                if (last) begin
                    case (idx)
                        2'd0:    p_hh  <= acc_nxt[2*W-1:0];
                        2'd1:    p_ll  <= acc_nxt[2*W-1:0];
                        default: p_mid <= acc_nxt[2*W+1:0];
                    endcase
                    idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_booth_seq.sv
// Bench for karatsuba_booth_seq: directed corner cases, backpressure, mid-run reset
// and a back-to-back random run scored against plain-arithmetic products.
module tb_karatsuba_booth_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_hi, a_lo, b_hi, b_lo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p_hh, p_ll;
    logic [33:0] p_mid;
    logic        busy;

    karatsuba_booth_seq #(.W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_hi      (a_hi),
        .a_lo      (a_lo),
        .b_hi      (b_hi),
        .b_lo      (b_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_hh      (p_hh),
        .p_ll      (p_ll),
        .p_mid     (p_mid),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] ah;
        logic [15:0] al;
        logic [15:0] bh;
        logic [15:0] bl;
        int          t;
    } op_t;

    op_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  prev_t = -1;
    bit  b2b = 1'b0;
    bit  ov_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_hh(input op_t o);
        return 64'(o.ah) * 64'(o.bh);
    endfunction

    function automatic logic [63:0] ref_ll(input op_t o);
        return 64'(o.al) * 64'(o.bl);
    endfunction

    function automatic logic [63:0] ref_mid(input op_t o);
        return (64'(o.ah) + 64'(o.al)) * (64'(o.bh) + 64'(o.bl));
    endfunction

    // Scoreboard: inputs and outputs are stable at the falling edge, so whatever is
    // seen here is exactly what the next rising edge acts on.
    always @(negedge clk) begin
        op_t o;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && !ov_prev) begin
                if (q.size() > 0)
                    check_val("latency", 64'(cyc - q[0].t), 64'd27);
                else
                    check_val("unexpected_out_valid", 64'(out_valid), 64'd0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                o = q.pop_front();
                check_val("p_hh", 64'(p_hh), ref_hh(o));
                check_val("p_ll", 64'(p_ll), ref_ll(o));
                check_val("p_mid", 64'(p_mid), ref_mid(o));
            end
            if (in_valid && in_ready) begin
                o.ah = a_hi;
                o.al = a_lo;
                o.bh = b_hi;
                o.bl = b_lo;
                o.t  = cyc + 1;
                if (b2b && prev_t >= 0)
                    check_val("accept_spacing", 64'(o.t - prev_t), 64'd29);
                prev_t = o.t;
                q.push_back(o);
            end
        end
        ov_prev = out_valid;
    end

    task automatic scramble();
        a_hi = 16'($urandom);
        a_lo = 16'($urandom);
        b_hi = 16'($urandom);
        b_lo = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] ah, input logic [15:0] al,
                        input logic [15:0] bh, input logic [15:0] bl);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_hi = ah;
        a_lo = al;
        b_hi = bh;
        b_lo = bl;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q.size() == 0 && in_ready) && n < 500);
        if (!(q.size() == 0 && in_ready)) check_val("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int acc_cnt;
        op_t o;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_p_hh", 64'(p_hh), 64'd0);
        check_val("rst_p_mid", 64'(p_mid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        out_ready = 1'b1;
        send(16'd1200, 16'd1300, 16'd1400, 16'd1002);
        wait_idle();
        check_val("dir_p_hh", 64'(p_hh), 64'd1680000);
        check_val("dir_p_ll", 64'(p_ll), 64'd1302600);
        check_val("dir_p_mid", 64'(p_mid), 64'd6005000);

        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_idle();
        check_val("max_p_hh", 64'(p_hh), 64'd4294836225);
        check_val("max_p_ll", 64'(p_ll), 64'd4294836225);
        check_val("max_p_mid", 64'(p_mid), 64'd17179344900);

        send(16'hAAAA, 16'h0000, 16'h5555, 16'h0000);
        wait_idle();
        check_val("booth_p_hh", 64'(p_hh), 64'd954408050);
        check_val("booth_p_ll", 64'(p_ll), 64'd0);
        check_val("booth_p_mid", 64'(p_mid), 64'd954408050);

        send(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        wait_idle();
        check_val("zero_p_hh", 64'(p_hh), 64'd0);
        check_val("zero_p_ll", 64'(p_ll), 64'd0);
        check_val("zero_p_mid", 64'(p_mid), 64'd0);

        // Backpressure with a new operand set waiting at the input.
        out_ready = 1'b0;
        send(16'd4321, 16'd999, 16'd65000, 16'd17);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_out_valid_rise", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_hi = 16'd7;
        a_lo = 16'd8;
        b_hi = 16'd9;
        b_lo = 16'd10;
        repeat (10) begin
            @(negedge clk);
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
            if (q.size() > 0) begin
                o = q[0];
                check_val("bp_p_hh_frozen", 64'(p_hh), ref_hh(o));
                check_val("bp_p_mid_frozen", 64'(p_mid), ref_mid(o));
            end else begin
                check_val("bp_queue", 64'(q.size()), 64'd1);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_hs_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        check_val("bp_after_out_valid", 64'(out_valid), 64'd0);
        check_val("bp_after_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        wait_idle();

        // Reset at T+12, then the first scenario again.
        send(16'd1200, 16'd1300, 16'd1400, 16'd1002);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_p_hh", 64'(p_hh), 64'd0);
        check_val("mid_rst_p_ll", 64'(p_ll), 64'd0);
        check_val("mid_rst_p_mid", 64'(p_mid), 64'd0);
        send(16'd1200, 16'd1300, 16'd1400, 16'd1002);
        wait_idle();
        check_val("post_rst_p_mid", 64'(p_mid), 64'd6005000);

        // Back-to-back random sets with in_valid and out_ready held high.
        b2b = 1'b1;
        prev_t = -1;
        acc_cnt = 0;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        scramble();
        while (acc_cnt < 100 && n < 5000) begin
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
            n++;
            if ($urandom_range(0, 3) == 0) a_hi = 16'hFFFF; else a_hi = 16'($urandom);
            a_lo = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b_hi = 16'hFFFF; else b_hi = 16'($urandom);
            b_lo = 16'($urandom);
            if (acc_cnt == 100) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check_val("b2b_accepts", 64'(acc_cnt), 64'd100);
        wait_idle();
        b2b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
